// File: rtl/joybus_pkg.sv
// Shared constants and types for the JOYBUS controller-to-UART path.
package joybus_pkg;

  localparam logic [7:0]  UART_SYNC_BYTE = 8'hA5;
  localparam int unsigned FRAME_BYTES    = 6;

  typedef enum logic {
    IDLE,
    SEND
  } framer_state_t;

  function automatic logic [7:0] frame_chk(input logic [31:0] d);
    return d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer; a start accepted on the stop bit's last clock gives gap-free bytes.
module uart_tx_byte #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       TX,
  output logic       byte_done
);

  localparam int unsigned   CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    data_q;
  logic          active;
  logic          next_bit;

  assign byte_done = active && (baud_cnt == CNT_LAST) && (bit_idx == 4'd9);

  // Level of the bit that follows bit_idx: data bits 1..8, then the stop bit.
  always_comb begin
    next_bit = 1'b1;
    if (bit_idx < 4'd8) next_bit = data_q[bit_idx[2:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      TX       <= 1'b1;
      active   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= '0;
    end else if (start && (!active || byte_done)) begin
      TX       <= 1'b0;
      active   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_q   <= tx_byte;
    end else if (active) begin
      if (baud_cnt == CNT_LAST) begin
        baud_cnt <= '0;
        if (bit_idx == 4'd9) begin
          TX      <= 1'b1;
          active  <= 1'b0;
          bit_idx <= '0;
        end else begin
          TX      <= next_bit;
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cntlr_uart_framer.sv
// Frames 32-bit controller snapshots as SYNC, 4 data bytes, XOR checksum over an 8N1 UART.
module cntlr_uart_framer
  import joybus_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter logic [7:0]  SYNC_BYTE   = UART_SYNC_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cntlr_data_rdy,
  input  logic [31:0] cntlr_data,
  output logic        TX,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned BAUD_DIV = CLK_FREQ_HZ / BAUD;
  localparam logic [2:0]  LAST_IDX = 3'(FRAME_BYTES - 1);

  framer_state_t                   state;
  logic [FRAME_BYTES-1:0][7:0]     frame_q;
  logic [2:0]                      byte_idx;
  logic [31:0]                     pend_q;
  logic                            pend_vld;
  logic                            tx_start;
  logic [7:0]                      tx_byte;
  logic                            byte_done;

  function automatic logic [FRAME_BYTES-1:0][7:0] build_frame(input logic [31:0] d);
    return {frame_chk(d), d[7:0], d[15:8], d[23:16], d[31:24], SYNC_BYTE};
  endfunction

  assign busy = (state == SEND);

  // The first byte is always SYNC, so a launch from IDLE need not wait for frame_q.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = SYNC_BYTE;
    if (state == IDLE) begin
      tx_start = cntlr_data_rdy || pend_vld;
    end else if (byte_done && (byte_idx != LAST_IDX)) begin
      tx_start = 1'b1;
      tx_byte  = frame_q[byte_idx + 3'd1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      frame_q    <= '0;
      byte_idx   <= '0;
      pend_q     <= '0;
      pend_vld   <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      case (state)
        IDLE: begin
          byte_idx <= '0;
          if (pend_vld) begin
            state   <= SEND;
            frame_q <= build_frame(pend_q);
            // A snapshot arriving now replaces the one being launched, so nothing is lost.
            if (cntlr_data_rdy) pend_q <= cntlr_data;
            else                pend_vld <= 1'b0;
          end else if (cntlr_data_rdy) begin
            state   <= SEND;
            frame_q <= build_frame(cntlr_data);
          end
        end
        SEND: begin
          if (byte_done) begin
            if (byte_idx == LAST_IDX) begin
              state      <= IDLE;
              frame_done <= 1'b1;
              byte_idx   <= '0;
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
          if (cntlr_data_rdy) begin
            pend_q   <= cntlr_data;
            pend_vld <= 1'b1;
            overrun  <= pend_vld;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (tx_start),
    .tx_byte  (tx_byte),
    .TX       (TX),
    .byte_done(byte_done)
  );

endmodule
